// File: rtl/grad_norm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : grad_norm_pkg                                          |
// | Description : Shared encodings, default widths and helpers for the   |
// |               piecewise-linear gradient-cost normaliser.             |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package grad_norm_pkg;

  // Table field selector carried on cfg_field
  typedef enum logic [1:0] {
    CFG_BP    = 2'd0,
    CFG_INT   = 2'd1,
    CFG_SLOPE = 2'd2,
    CFG_RSVD  = 2'd3
  } cfg_field_e;

  localparam int DEF_IN_W       = 12;
  localparam int DEF_OUT_W      = 11;
  localparam int DEF_NSEG       = 16;
  localparam int DEF_SLOPE_W    = 12;
  localparam int DEF_SLOPE_FRAC = 10;
  localparam int DEF_CNT_W      = 16;

  // Ceiling log2, at least 1 for any n >= 2
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/grad_norm_pwl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : grad_norm_pwl_if                                       |
// | Description : Sample stream, result stream, table programming and    |
// |               saturation-counter signals of the PWL normaliser.      |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface grad_norm_pwl_if
  import grad_norm_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int NSEG    = DEF_NSEG,
  parameter int SLOPE_W = DEF_SLOPE_W,
  parameter int CNT_W   = DEF_CNT_W
);
  localparam int SEG_W = clog2(NSEG);
  localparam int WD_W  = (IN_W > OUT_W) ? ((IN_W > SLOPE_W) ? IN_W : SLOPE_W)
                                        : ((OUT_W > SLOPE_W) ? OUT_W : SLOPE_W);

  logic               in_valid;
  logic               in_ready;
  logic [IN_W-1:0]    in_cost;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_norm;
  logic               out_sat;
  logic               cfg_we;
  logic [SEG_W-1:0]   cfg_addr;
  logic [1:0]         cfg_field;
  logic [WD_W-1:0]    cfg_wdata;
  logic [CNT_W-1:0]   sat_cnt;
  logic               sat_clr;

  modport master (
    output in_valid, in_cost, out_ready, cfg_we, cfg_addr, cfg_field, cfg_wdata, sat_clr,
    input  in_ready, out_valid, out_norm, out_sat, sat_cnt
  );

  modport slave (
    input  in_valid, in_cost, out_ready, cfg_we, cfg_addr, cfg_field, cfg_wdata, sat_clr,
    output in_ready, out_valid, out_norm, out_sat, sat_cnt
  );

endinterface
`default_nettype wire

// File: rtl/grad_norm_seg_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : grad_norm_seg_sel                                      |
// | Description : Priority match of a cost against the PWL breakpoints;  |
// |               returns the highest index whose breakpoint <= x.       |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module grad_norm_seg_sel
  import grad_norm_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int NSEG  = DEF_NSEG,
  parameter int SEG_W = clog2(NSEG)
)(
  input  logic [IN_W-1:0]            x,
  input  logic [NSEG-1:0][IN_W-1:0]  bp,
  output logic [SEG_W-1:0]           seg
);

  // Ascending scan so the last (highest) matching index wins; entry 0 is
  // always zero, so the result is defined even for non-monotonic tables.
  always_comb begin
    seg = '0;
    for (int i = 0; i < NSEG; i++) begin
      if (bp[i] <= x) begin
        seg = SEG_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/grad_norm_pwl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : grad_norm_pwl                                          |
// | Description : 3-stage pipelined PWL gradient-cost normaliser:        |
// |               out = max(0, intercept[s] - slope[s]*(x - bp[s])).     |
// |               Programmable table, valid/ready flow control and a     |
// |               saturating count of floored results.                   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module grad_norm_pwl
  import grad_norm_pkg::*;
#(
  parameter int IN_W       = DEF_IN_W,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int NSEG       = DEF_NSEG,
  parameter int SLOPE_W    = DEF_SLOPE_W,
  parameter int SLOPE_FRAC = DEF_SLOPE_FRAC,
  parameter int CNT_W      = DEF_CNT_W
)(
  input  logic            clk,
  input  logic            rst,
  grad_norm_pwl_if.slave  bus
);

  localparam int SEG_W  = clog2(NSEG);
  localparam int PROD_W = IN_W + SLOPE_W;

  // Coefficient table
  logic [NSEG-1:0][IN_W-1:0]    bp_tab;
  logic [NSEG-1:0][OUT_W-1:0]   int_tab;
  logic [NSEG-1:0][SLOPE_W-1:0] slope_tab;

  // Pipeline state
  logic                en;
  logic [SEG_W-1:0]    seg;
  logic [IN_W-1:0]     dx;
  logic                s1_valid;
  logic [IN_W-1:0]     s1_dx;
  logic [OUT_W-1:0]    s1_int;
  logic [SLOPE_W-1:0]  s1_slope;
  logic [PROD_W-1:0]   prod_full;
  logic [PROD_W-1:0]   prod_scaled;
  logic                s2_valid;
  logic [PROD_W-1:0]   s2_prod;
  logic [OUT_W-1:0]    s2_int;
  logic                floored;
  logic [OUT_W-1:0]    norm_next;
  logic                s3_valid;
  logic [OUT_W-1:0]    s3_norm;
  logic                s3_sat;
  logic [CNT_W-1:0]    sat_count;

  // Whole pipeline moves as one unit: free output slot or consumer taking it
  assign en           = !s3_valid | bus.out_ready;
  assign bus.in_ready = en;

  // Table writes; entry 0 breakpoint is never written so it stays at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bp_tab    <= '0;
      int_tab   <= '0;
      slope_tab <= '0;
    end else if (bus.cfg_we) begin
      case (cfg_field_e'(bus.cfg_field))
        CFG_BP:    if (bus.cfg_addr != '0) bp_tab[bus.cfg_addr] <= bus.cfg_wdata[IN_W-1:0];
        CFG_INT:   int_tab[bus.cfg_addr]   <= bus.cfg_wdata[OUT_W-1:0];
        CFG_SLOPE: slope_tab[bus.cfg_addr] <= bus.cfg_wdata[SLOPE_W-1:0];
        default:   ;
      endcase
    end
  end

  grad_norm_seg_sel #(
    .IN_W  (IN_W),
    .NSEG  (NSEG),
    .SEG_W (SEG_W)
  ) u_seg_sel (
    .x   (bus.in_cost),
    .bp  (bp_tab),
    .seg (seg)
  );

  // Selected breakpoint never exceeds x, so the offset is non-negative
  assign dx = bus.in_cost - bp_tab[seg];

  // S1: capture offset and the coefficients of the matched segment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_dx    <= '0;
      s1_int   <= '0;
      s1_slope <= '0;
    end else if (en) begin
      s1_valid <= bus.in_valid;
      s1_dx    <= dx;
      s1_int   <= int_tab[seg];
      s1_slope <= slope_tab[seg];
    end
  end

  assign prod_full   = PROD_W'(s1_dx) * PROD_W'(s1_slope);
  assign prod_scaled = prod_full >> SLOPE_FRAC;

  // S2: scaled product, fractional bits truncated
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_prod  <= '0;
      s2_int   <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_prod  <= prod_scaled;
      s2_int   <= s1_int;
    end
  end

  // Negative difference is detected by magnitude compare; when not floored
  // the product is below the intercept, so its low OUT_W bits suffice.
  assign floored   = s2_prod > PROD_W'(s2_int);
  assign norm_next = s2_int - s2_prod[OUT_W-1:0];

  // S3: output register with floor at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s3_valid <= 1'b0;
      s3_norm  <= '0;
      s3_sat   <= 1'b0;
    end else if (en) begin
      s3_valid <= s2_valid;
      s3_norm  <= floored ? '0 : norm_next;
      s3_sat   <= s2_valid & floored;
    end
  end

  // Saturating count of floored results taken downstream; clear wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_count <= '0;
    end else if (bus.sat_clr) begin
      sat_count <= '0;
    end else if (s3_valid && bus.out_ready && s3_sat && !(&sat_count)) begin
      sat_count <= sat_count + 1'b1;
    end
  end

  assign bus.out_valid = s3_valid;
  assign bus.out_norm  = s3_norm;
  assign bus.out_sat   = s3_sat;
  assign bus.sat_cnt   = sat_count;

endmodule
`default_nettype wire
